// File: rtl/stone_drawer_pkg.sv
// Shared definitions for the stone drawer: RAM record layout, stone types, palette,
// screen geometry defaults and the pass FSM encoding.
package stone_drawer_pkg;

  localparam int unsigned SpriteDefault  = 16;
  localparam int unsigned ScreenWDefault = 320;
  localparam int unsigned ScreenHDefault = 240;
  localparam int unsigned ColourWDefault = 3;
  localparam int unsigned RecW           = 32;

  typedef enum logic [1:0] {
    TypeStone   = 2'd0,
    TypeGold    = 2'd1,
    TypeDiamond = 2'd2,
    TypeGem     = 2'd3
  } stone_type_e;

  localparam logic [2:0] ColourStone   = 3'b111;
  localparam logic [2:0] ColourGold    = 3'b110;
  localparam logic [2:0] ColourDiamond = 3'b011;

  // Layout of one stone record as written by the rope controller (MSB first).
  typedef struct packed {
    logic [8:0]  x;
    logic [3:0]  rsvd_hi;
    logic [7:0]  y;
    logic [6:0]  rsvd_lo;
    stone_type_e kind;
    logic        visible;
    logic        moving;
  } stone_rec_t;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StLatch,
    StDraw,
    StNext,
    StDone
  } draw_state_e;

  function automatic logic [2:0] type_colour(stone_type_e kind);
    logic [2:0] colour;
    case (kind)
      TypeStone: colour = ColourStone;
      TypeGold:  colour = ColourGold;
      default:   colour = ColourDiamond;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/stone_drawer_sprite_scan.sv
// Raster counters for one sprite: px runs fastest, py advances when px wraps.
// last_o flags the final pixel so the owner can leave its draw state.
module stone_drawer_sprite_scan #(
  parameter  int unsigned Sprite = 16,
  localparam int unsigned CntW   = $clog2(Sprite)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic [CntW-1:0] px_o,
  output logic [CntW-1:0] py_o,
  output logic            last_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(Sprite - 1);

  logic [CntW-1:0] px_q, px_d;
  logic [CntW-1:0] py_q, py_d;
  logic            busy_q, busy_d;

  assign last_o = busy_q && (px_q == CntMax) && (py_q == CntMax);
  assign busy_o = busy_q;
  assign px_o   = px_q;
  assign py_o   = py_q;

  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    busy_d = busy_q;
    if (start_i) begin
      px_d   = '0;
      py_d   = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Power-of-two edge: both counters wrap back to zero after the last pixel.
      px_d = px_q + CntW'(1);
      if (px_q == CntMax) begin
        py_d = py_q + CntW'(1);
      end
      if (last_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      px_q   <= '0;
      py_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/stone_drawer.sv
// Per-frame stone renderer: walks the stone-record RAM and emits one 16x16 solid sprite
// per visible record as clipped pixel writes to the VGA adapter.
module stone_drawer
  import stone_drawer_pkg::*;
#(
  parameter int unsigned Sprite  = SpriteDefault,
  parameter int unsigned ScreenW = ScreenWDefault,
  parameter int unsigned ScreenH = ScreenHDefault,
  parameter int unsigned ColourW = ColourWDefault
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [3:0]         quantity_i,
  input  logic [RecW-1:0]    data_i,
  output logic               draw_stone_flag_o,
  output logic [3:0]         draw_index_o,
  output logic [8:0]         vga_x_o,
  output logic [7:0]         vga_y_o,
  output logic [ColourW-1:0] vga_colour_o,
  output logic               plot_o,
  output logic               done_o
);

  localparam int unsigned CntW = $clog2(Sprite);

  draw_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  qty_q, qty_d;

  stone_rec_t  rec_in;
  logic [8:0]  rec_x_q;
  logic [7:0]  rec_y_q;
  stone_type_e rec_type_q;

  logic            scan_start;
  logic            scan_busy;
  logic            scan_last;
  logic [CntW-1:0] px;
  logic [CntW-1:0] py;
  logic [9:0]      sum_x;
  logic [9:0]      sum_y;

  logic               flag_q, flag_d;
  logic [3:0]         index_q, index_d;
  logic [8:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [ColourW-1:0] colour_q, colour_d;
  logic               plot_q, plot_d;
  logic               done_q, done_d;

  logic unused_data;

  assign rec_in      = stone_rec_t'(data_i);
  assign unused_data = ^{rec_in.rsvd_hi, rec_in.rsvd_lo, rec_in.moving, scan_busy};

  stone_drawer_sprite_scan #(
    .Sprite (Sprite)
  ) u_scan (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .start_i (scan_start),
    .busy_o  (scan_busy),
    .px_o    (px),
    .py_o    (py),
    .last_o  (scan_last)
  );

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    qty_d      = qty_q;
    scan_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          qty_d   = quantity_i;
          idx_d   = '0;
          state_d = (quantity_i == 4'd0) ? StDone : StReq;
        end
      end
      StReq:  state_d = StWait;
      StWait: state_d = StLatch;
      StLatch: begin
        if (rec_in.visible) begin
          state_d    = StDraw;
          scan_start = 1'b1;
        end else begin
          state_d = StNext;
        end
      end
      StDraw: begin
        if (scan_last) begin
          state_d = StNext;
        end
      end
      StNext: begin
        idx_d   = idx_q + 4'd1;
        state_d = (idx_d == qty_q) ? StDone : StReq;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic. The RAM-ownership flag and address are decoded from the next state so
  // they line up with REQ/WAIT/LATCH; pixel and done outputs trail the counters by a cycle.
  always_comb begin
    sum_x    = {1'b0, rec_x_q} + 10'(px);
    sum_y    = {2'b00, rec_y_q} + 10'(py);
    flag_d   = (state_d == StReq) || (state_d == StWait) || (state_d == StLatch);
    index_d  = (state_d == StReq) ? idx_d : index_q;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    done_d   = (state_q == StDone);
    if (state_q == StDraw) begin
      plot_d   = (sum_x < 10'(ScreenW)) && (sum_y < 10'(ScreenH));
      x_d      = sum_x[8:0];
      y_d      = sum_y[7:0];
      colour_d = ColourW'(type_colour(rec_type_q));
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q      <= '0;
      qty_q      <= '0;
      rec_x_q    <= '0;
      rec_y_q    <= '0;
      rec_type_q <= TypeStone;
    end else begin
      idx_q <= idx_d;
      qty_q <= qty_d;
      // Latched once per record so later RAM writes cannot disturb the sprite in flight.
      if (state_q == StLatch) begin
        rec_x_q    <= rec_in.x;
        rec_y_q    <= rec_in.y;
        rec_type_q <= rec_in.kind;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      flag_q   <= 1'b0;
      index_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      flag_q   <= flag_d;
      index_q  <= index_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

  assign draw_stone_flag_o = flag_q;
  assign draw_index_o      = index_q;
  assign vga_x_o           = x_q;
  assign vga_y_o           = y_q;
  assign vga_colour_o      = colour_q;
  assign plot_o            = plot_q;
  assign done_o            = done_q;

endmodule

// File: tb/tb_stone_drawer.sv
// Bench for stone_drawer: RAM model, per-cycle expectation tables built from the record
// rules (costs, raster order, clipping, palette) and literal checks on pass statistics.
module tb_stone_drawer;

  localparam int MaxT = 4200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  quantity = '0;
  logic [31:0] data;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        done;

  stone_drawer dut (
    .clock_i           (clock),
    .reset_i           (reset),
    .enable_i          (enable),
    .quantity_i        (quantity),
    .data_i            (data),
    .draw_stone_flag_o (draw_stone_flag),
    .draw_index_o      (draw_index),
    .vga_x_o           (vga_x),
    .vga_y_o           (vga_y),
    .vga_colour_o      (vga_colour),
    .plot_o            (plot),
    .done_o            (done)
  );

  always #5 clock = ~clock;

  // Record RAM with registered read data.
  logic [31:0] mem [16];
  always @(posedge clock) data <= mem[draw_index];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected behaviour, indexed by cycles since the cycle enable was driven.
  bit exp_plot [MaxT];
  int exp_x    [MaxT];
  int exp_y    [MaxT];
  int exp_col  [MaxT];
  bit exp_flag [MaxT];
  int exp_idx  [MaxT];
  bit exp_done [MaxT];
  int model_len;

  bit chk_on = 1'b0;
  int chk_t  = 0;

  int plot_cnt, flag_cnt, done_cnt, done_at, clip_viol;
  int first_x, first_y, last_x, last_y, last_col;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_rec(input int x, input int y, input int typ,
                                         input bit vis, input bit mov);
    logic [31:0] r;
    r          = '0;
    r[31:23]   = 9'(x);
    r[22:19]   = 4'hA;
    r[18:11]   = 8'(y);
    r[10:4]    = 7'h55;
    r[3:2]     = 2'(typ);
    r[1]       = vis;
    r[0]       = mov;
    return r;
  endfunction

  function automatic int colour_of(input int typ);
    if (typ == 0) return 7;
    if (typ == 1) return 6;
    return 3;
  endfunction

  function automatic void build_model(input int q);
    int b;
    int x;
    int y;
    logic [31:0] rec;
    for (int t = 0; t < MaxT; t++) begin
      exp_plot[t] = 1'b0;
      exp_flag[t] = 1'b0;
      exp_done[t] = 1'b0;
      exp_idx[t]  = -1;
    end
    b = 1;
    for (int r = 0; r < q; r++) begin
      rec = mem[r];
      for (int k = 0; k < 3; k++) exp_flag[b + k] = 1'b1;
      exp_idx[b] = r;
      if (rec[1]) begin
        for (int k = 0; k < 256; k++) begin
          x = int'(rec[31:23]) + k % 16;
          y = int'(rec[18:11]) + k / 16;
          if (x < 320 && y < 240) begin
            exp_plot[b + 4 + k] = 1'b1;
            exp_x[b + 4 + k]    = x;
            exp_y[b + 4 + k]    = y;
            exp_col[b + 4 + k]  = colour_of(int'(rec[3:2]));
          end
        end
        b += 260;
      end else begin
        b += 4;
      end
    end
    exp_done[b + 1] = 1'b1;
    model_len = b + 2;
  endfunction

  always @(negedge clock) begin
    if (chk_on && chk_t < MaxT) begin
      check("plot", int'(plot), int'(exp_plot[chk_t]));
      check("flag", int'(draw_stone_flag), int'(exp_flag[chk_t]));
      check("done", int'(done), int'(exp_done[chk_t]));
      if (exp_idx[chk_t] >= 0) check("draw_index", int'(draw_index), exp_idx[chk_t]);
      if (exp_plot[chk_t] && plot) begin
        check("vga_x", int'(vga_x), exp_x[chk_t]);
        check("vga_y", int'(vga_y), exp_y[chk_t]);
        check("vga_colour", int'(vga_colour), exp_col[chk_t]);
      end
      if (plot) begin
        if (plot_cnt == 0) begin
          first_x = int'(vga_x);
          first_y = int'(vga_y);
        end
        last_x   = int'(vga_x);
        last_y   = int'(vga_y);
        last_col = int'(vga_colour);
        plot_cnt++;
        if (vga_x >= 9'd320 || vga_y >= 8'd240) clip_viol++;
      end
      if (draw_stone_flag) flag_cnt++;
      if (done) begin
        done_cnt++;
        done_at = chk_t;
      end
      chk_t++;
    end
  end

  task automatic start_pass(input int q);
    @(posedge clock);
    #1;
    quantity  = 4'(q);
    enable    = 1'b1;
    build_model(q);
    plot_cnt  = 0;
    flag_cnt  = 0;
    done_cnt  = 0;
    done_at   = -1;
    clip_viol = 0;
    first_x   = -1;
    first_y   = -1;
    chk_t     = 0;
    chk_on    = 1'b1;
    @(posedge clock);
    #1;
    enable = 1'b0;
  endtask

  task automatic run_out();
    repeat (model_len + 3) @(posedge clock);
    #1;
    chk_on = 1'b0;
  endtask

  initial begin
    int d;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_flag", int'(draw_stone_flag), 0);
    check("reset_plot", int'(plot), 0);
    check("reset_done", int'(done), 0);
    check("reset_index", int'(draw_index), 0);
    check("reset_vga_x", int'(vga_x), 0);
    reset = 1'b0;

    // T1: single visible gold stone.
    mem[0] = mk_rec(100, 50, 1, 1'b1, 1'b0);
    start_pass(1);
    run_out();
    check("t1_plots", plot_cnt, 256);
    check("t1_first_x", first_x, 100);
    check("t1_first_y", first_y, 50);
    check("t1_last_x", last_x, 115);
    check("t1_last_y", last_y, 65);
    check("t1_colour", last_col, 6);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_flag_cycles", flag_cnt, 3);
    check("t1_done_at", done_at, 262);

    // T2: middle record invisible; last record moving.
    mem[0] = mk_rec(10, 20, 0, 1'b1, 1'b0);
    mem[1] = mk_rec(50, 60, 2, 1'b0, 1'b0);
    mem[2] = mk_rec(200, 100, 3, 1'b1, 1'b1);
    start_pass(3);
    run_out();
    check("t2_plots", plot_cnt, 512);
    check("t2_done_at", done_at, 526);
    check("t2_flag_cycles", flag_cnt, 9);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_last_colour", last_col, 3);

    // T3: sprite straddling the bottom-right corner.
    mem[0] = mk_rec(310, 230, 2, 1'b1, 1'b0);
    start_pass(1);
    run_out();
    check("t3_plots", plot_cnt, 100);
    check("t3_clip_viol", clip_viol, 0);
    check("t3_first_x", first_x, 310);
    check("t3_last_x", last_x, 319);
    check("t3_last_y", last_y, 239);

    // T4: empty pass.
    start_pass(0);
    run_out();
    check("t4_done_at", done_at, 2);
    check("t4_flag_cycles", flag_cnt, 0);
    check("t4_plots", plot_cnt, 0);

    // T5: reset in the middle of drawing record 0.
    mem[0] = mk_rec(20, 30, 0, 1'b1, 1'b0);
    mem[1] = mk_rec(60, 70, 1, 1'b1, 1'b0);
    start_pass(2);
    repeat (50) @(posedge clock);
    #1;
    chk_on = 1'b0;
    check("t5_pre_plot", int'(plot), 1);
    reset = 1'b1;
    #1;
    check("t5_plot", int'(plot), 0);
    check("t5_flag", int'(draw_stone_flag), 0);
    check("t5_done", int'(done), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    d = 0;
    repeat (10) begin
      @(negedge clock);
      if (done || draw_stone_flag || plot) d++;
    end
    check("t5_quiet_after_reset", d, 0);
    start_pass(2);
    run_out();
    check("t5_restart_plots", plot_cnt, 512);
    check("t5_restart_first_x", first_x, 20);
    check("t5_restart_done_cnt", done_cnt, 1);

    // T6: stray enable and a record rewrite while record 0 is drawing.
    mem[0] = mk_rec(40, 60, 1, 1'b1, 1'b0);
    mem[1] = mk_rec(80, 90, 0, 1'b1, 1'b0);
    start_pass(2);
    repeat (20) @(posedge clock);
    #1;
    enable   = 1'b1;
    quantity = 4'd5;
    @(posedge clock);
    #1;
    enable = 1'b0;
    mem[0] = mk_rec(40, 150, 1, 1'b1, 1'b0);
    run_out();
    check("t6_done_cnt", done_cnt, 1);
    check("t6_plots", plot_cnt, 512);
    check("t6_first_y", first_y, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
